// File: rtl/task_worker_mul.sv
// task_worker_mul: start/done handshake responder that runs an unsigned
// shift-add multiply, one multiplier bit per clock, with fixed latency.
module task_worker_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 start_err
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [PW-1:0]    result_q, result_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic [PW-1:0]    sum;

  // Next-state, datapath step and Moore output decode from the next state
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(operand_a);
          mplier_d = operand_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = sum;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = start && (state_q != IDLE);
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign start_err = err_q;

endmodule

// File: tb/tb_task_worker_mul.sv
// tb_task_worker_mul: directed, table-driven checks of the multiply worker.
module tb_task_worker_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        start_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] st;   // start per cycle 0..11 (bit 0 = accepted start)
    logic [15:0] err;  // expected start_err per cycle 0..11
    logic [15:0] res;
  } vec_t;

  vec_t vecs [5];

  task_worker_mul #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then sit at the falling edge to sample
  task automatic step(input logic st, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    start     = st;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input logic [15:0] prev);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) step(v.st[c], v.a, v.b);
      else        step(v.st[c], 8'd3, 8'd3);
      check("busy", c, 32'(busy), 32'(c >= 1 && c <= 9));
      check("done", c, 32'(done), 32'(c == 9));
      check("start_err", c, 32'(start_err), 32'(v.err[c]));
      check("result", c, 32'(result), 32'(c >= 9 ? v.res : prev));
    end
  endtask

  initial begin
    vec_t tmp;
    logic [15:0] prev;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  st: 16'h0001, err: 16'h0000, res: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, st: 16'h0001, err: 16'h0000, res: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, st: 16'h0001, err: 16'h0000, res: 16'd0};
    vecs[3] = '{a: 8'd7,   b: 8'd6,   st: 16'h0011, err: 16'h0020, res: 16'd42};
    vecs[4] = '{a: 8'd5,   b: 8'd5,   st: 16'h0007, err: 16'h000C, res: 16'd25};

    start = 1'b0; operand_a = '0; operand_b = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 0, 32'(busy), 32'd0);
    check("rst_done", 0, 32'(done), 32'd0);
    check("rst_err", 0, 32'(start_err), 32'd0);
    check("rst_result", 0, 32'(result), 32'd0);
    reset = 1'b0;

    // Table of single jobs, including overlapped and held starts
    prev = 16'd0;
    for (int i = 0; i < 5; i++) begin
      tmp = vecs[i];
      run_vec(tmp, prev);
      prev = tmp.res;
    end

    // Start in DONE is an error; start in the following IDLE cycle is accepted
    step(1'b1, 8'd9, 8'd9);
    for (int c = 1; c <= 8; c++) step(1'b0, 8'd0, 8'd0);
    step(1'b1, 8'd1, 8'd1);
    check("b2b_done9", 9, 32'(done), 32'd1);
    check("b2b_res9", 9, 32'(result), 32'd81);
    step(1'b1, 8'd2, 8'd9);
    check("b2b_err10", 10, 32'(start_err), 32'd1);
    check("b2b_busy10", 10, 32'(busy), 32'd0);
    check("b2b_done10", 10, 32'(done), 32'd0);
    for (int c = 11; c <= 20; c++) begin
      step(1'b0, 8'd7, 8'd7);
      check("b2b_busy", c, 32'(busy), 32'(c <= 19));
      check("b2b_done", c, 32'(done), 32'(c == 19));
      check("b2b_err", c, 32'(start_err), 32'd0);
      check("b2b_result", c, 32'(result), 32'(c >= 19 ? 16'd18 : 16'd81));
    end

    // Asynchronous reset in the middle of a job abandons it
    step(1'b1, 8'd100, 8'd3);
    for (int c = 1; c <= 4; c++) step(1'b0, 8'd0, 8'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 5, 32'(busy), 32'd0);
    check("mid_rst_done", 5, 32'(done), 32'd0);
    check("mid_rst_result", 5, 32'(result), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 8'd0, 8'd0);
      check("post_rst_done", c, 32'(done), 32'd0);
      check("post_rst_busy", c, 32'(busy), 32'd0);
    end
    tmp = '{a: 8'd4, b: 8'd4, st: 16'h0001, err: 16'h0000, res: 16'd16};
    run_vec(tmp, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/task_worker_mul.md
Name: task_worker_mul

Overview:
- Responder end of the start/done task handshake used by the sequencer FSMs: one `start` pulse launches a job and one `done` pulse reports its completion.
- The job is an unsigned shift-add multiply of two operands, one multiplier bit per clock.
- Instances sit on the `start_x` / `done_x` pairs of a sequencer.
- Outputs are Moore-style, decoded from registered state only.

Parameters:
- `WIDTH`, 8, operand width in bits; legal range 2..32.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request, sampled on `clk`; one-cycle pulse expected.
- `operand_a`  in  `WIDTH`  multiplicand, captured on accepted start.
- `operand_b`  in  `WIDTH`  multiplier, captured on accepted start.
- `busy`  out  1  high while a job is in progress (state != IDLE).
- `done`  out  1  one-cycle completion pulse (state == DONE).
- `result`  out  `2*WIDTH`  product; registered; held until the next accepted start.
- `start_err`  out  1  registered one-cycle pulse: start was seen while not IDLE.

Behaviour:
- Reset, asynchronous, effective immediately whenever `reset`=1:
  - state=IDLE; `busy`=0, `done`=0, `start_err`=0.
  - `result`=0; internal accumulator, operand copies and count all 0.
- States: IDLE, RUN, DONE. Encoding is free, but there are no illegal reachable states; the unused encoding returns to IDLE.
- IDLE:
  - `start`=1 at an edge: latch `operand_a` into the multiplicand shift register (2*`WIDTH` wide, zero-extended), latch `operand_b` into the multiplier shift register, clear accumulator, clear count, go to RUN.
  - `start`=0: stay in IDLE.
- RUN, each edge:
  - If multiplier LSB=1: accumulator += multiplicand (2*`WIDTH`-bit add, no overflow possible).
  - Then multiplicand <<= 1, multiplier >>= 1, count += 1.
  - When count reaches `WIDTH`-1 on this edge (the `WIDTH`-th iteration), go to DONE and load `result` with the final accumulator value, including this iteration's add.
  - Count width is clog2(`WIDTH`+1).
- DONE: unconditionally go to IDLE on the next edge.
- Latency:
  - `start` high in cycle 0 gives RUN in cycles 1..`WIDTH`, DONE in cycle `WIDTH`+1, IDLE in cycle `WIDTH`+2.
  - For `WIDTH`=8, `done` is high in cycle 9 only.
- Fixed latency: no early exit when operands are 0.
- `result` becomes valid in the DONE cycle and stays stable through IDLE until the next job's DONE. It is not cleared on accept.
- `busy`=1 in RUN and DONE, 0 in IDLE.
- Operand changes after the accept edge are ignored.
- `start` while in RUN or DONE:
  - Ignored: no restart, no operand capture, no effect on the in-flight result.
  - `start_err`=1 in the following cycle, for one cycle per offending cycle.
- `start` held high for k cycles from IDLE: the first cycle is accepted; the remaining k-1 cycles each produce a `start_err` pulse, one cycle later.
- Back-to-back: a `start` in the first IDLE cycle after DONE (cycle `WIDTH`+2) is accepted normally. A `start` in the DONE cycle itself is an error.
- Reset mid-job: the job is abandoned, no `done` is produced, and `result`=0. The next start after reset release behaves as from power-up.

Test Plan:
- Reset, then `operand_a`=13, `operand_b`=11, `start` pulsed in cycle 0 -> `busy`=1 in cycles 1..9; `done`=1 only in cycle 9; `result`=143 from cycle 9 and still 143 in cycle 20.
- `operand_a`=255, `operand_b`=255 -> `result`=65025 (0xFE01) at `done`. `operand_a`=0, `operand_b`=200 -> `result`=0 with `done` still in cycle 9 (no early exit).
- Job 7*6 started in cycle 0; `start` pulsed in cycle 4 with operands 3,3 -> `start_err`=1 in cycle 5 only; `done` in cycle 9 with `result`=42.
- `start` held high for 3 cycles from IDLE (operands 5,5) -> `start_err` in cycles 2 and 3; `done` in cycle 9; `result`=25.
- `start` pulsed in the DONE cycle 9 -> `start_err` in cycle 10, no new job. `start` in cycle 10 with operands 2,9 -> `done` in cycle 19, `result`=18.
- Job 100*3 started; `reset` asserted asynchronously mid-cycle 5 -> `busy`, `done`, `result` go to 0 immediately. After release, no `done` appears within 20 cycles. A new job 4*4 gives `result`=16 at the expected latency.
